// File: rtl/input_conditioner_pkg.sv
// Shared defaults and sizing helper for the mechanical-input conditioner.
package input_conditioner_pkg;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_LONG_CYCLES     = 1024;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: sync chain, counter debouncer, press/release/long pulses.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic n_in_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   db_q, db_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_q, rel_q;

    assign s = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (!en_i) begin
            db_d  = 1'b0;
            cnt_d = '0;
        end else if (s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sync chain keeps running while disabled so re-enable sees a settled level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], n_in_i};
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= db_d & ~db_q;
            rel_q   <= db_q & ~db_d & en_i;
        end
    end

    assign pressed_o = db_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

    generate
        if (LONG_CYCLES > 0) begin : g_long
            localparam int HW = cnt_width(LONG_CYCLES);
            localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);

            logic [HW-1:0] h_q, h_d;
            logic          long_q;

            // Count only cycles that were already pressed and stay pressed, so h
            // reaches LONG_CYCLES exactly LONG_CYCLES cycles after the press pulse.
            always_comb begin
                h_d = '0;
                if (db_q && db_d)
                    h_d = (h_q == H_MAX) ? h_q : h_q + 1'b1;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    h_q    <= '0;
                    long_q <= 1'b0;
                end else begin
                    h_q    <= h_d;
                    long_q <= (h_d == H_MAX) && (h_q != H_MAX);
                end
            end

            assign long_o = long_q;
        end else begin : g_nolong
            assign long_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/input_conditioner.sv
// N-channel conditioner for active-low buttons and reed/hall sensors.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [NUM_CH-1:0] ChEnable,
    input  logic [NUM_CH-1:0] nIn,
    output logic [NUM_CH-1:0] Pressed,
    output logic [NUM_CH-1:0] PressPulse,
    output logic [NUM_CH-1:0] ReleasePulse,
    output logic [NUM_CH-1:0] LongPulse,
    output logic              AnyEvent
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            input_conditioner_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .LONG_CYCLES    (LONG_CYCLES)
            ) u_ch (
                .clk_i    (Clock),
                .rst_ni   (nReset),
                .en_i     (ChEnable[i]),
                .n_in_i   (nIn[i]),
                .pressed_o(Pressed[i]),
                .press_o  (PressPulse[i]),
                .release_o(ReleasePulse[i]),
                .long_o   (LongPulse[i])
            );
        end
    endgenerate

    assign AnyEvent = |{PressPulse, ReleasePulse, LongPulse};

endmodule
